// File: rtl/video_timing.sv
// Free-running raster timing generator: counts pixel clocks into line/frame
// positions and emits registered sync, active-video, coordinate and start strobes.
module video_timing #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int XW        = 11,
  parameter int YW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          hsync,
  output logic          vsync,
  output logic          data_en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_timing
    $error("video_timing: all timing parameters must be greater than zero");
  end
  if (XW < 1 || XW > 30 || H_TOTAL > (1 << XW)) begin : g_bad_xw
    $error("video_timing: XW too narrow for H_TOTAL");
  end
  if (YW < 1 || YW > 30 || V_TOTAL > (1 << YW)) begin : g_bad_yw
    $error("video_timing: YW too narrow for V_TOTAL");
  end

  logic [XW-1:0] h_cnt_q, h_cnt_d;
  logic [YW-1:0] v_cnt_q, v_cnt_d;
  logic          h_last, v_last;
  logic          h_act, v_act, hs_win, vs_win, active;

  logic          hsync_q, vsync_q, data_en_q, line_start_q, frame_start_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  // NOTE: every variable driven here gets a default on the first lines, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    h_last  = (h_cnt_q == XW'(H_TOTAL - 1));
    v_last  = (v_cnt_q == YW'(V_TOTAL - 1));
    h_cnt_d = h_last ? '0 : h_cnt_q + XW'(1);
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + YW'(1);
    end
  end

  // Decode of the current position; registered below, hence one clock behind the counters.
  assign h_act  = (h_cnt_q < XW'(H_ACTIVE));
  assign v_act  = (v_cnt_q < YW'(V_ACTIVE));
  assign hs_win = (h_cnt_q >= XW'(HS_START)) && (h_cnt_q < XW'(HS_END));
  assign vs_win = (v_cnt_q >= YW'(VS_START)) && (v_cnt_q < YW'(VS_END));
  assign active = h_act && v_act;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      data_en_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hs_win ? HSYNC_POL : ~HSYNC_POL;
      vsync_q       <= vs_win ? VSYNC_POL : ~VSYNC_POL;
      data_en_q     <= active;
      x_q           <= active ? h_cnt_q : '0;
      y_q           <= active ? v_cnt_q : '0;
      line_start_q  <= (h_cnt_q == '0);
      frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign data_en     = data_en_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: default, small and inverted-polarity instances checked each
// clock against an arithmetic raster model, plus measured widths, periods and resets.
module tb_video_timing;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] x;
    logic [9:0]  y;
    logic        ls;
    logic        fs;
  } vt_t;

  logic clk = 1'b0;
  logic rst_n;
  always #13 clk = ~clk;

  logic        d_hs, d_vs, d_de, d_ls, d_fs;
  logic [10:0] d_x;
  logic [9:0]  d_y;
  logic        s_hs, s_vs, s_de, s_ls, s_fs;
  logic [10:0] s_x;
  logic [9:0]  s_y;
  logic        p_hs, p_vs, p_de, p_ls, p_fs;
  logic [10:0] p_x;
  logic [9:0]  p_y;

  video_timing dut_def (
    .clk(clk), .rst_n(rst_n), .hsync(d_hs), .vsync(d_vs), .data_en(d_de),
    .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
  );

  video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .hsync(s_hs), .vsync(s_vs), .data_en(s_de),
    .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
  );

  video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_pol (
    .clk(clk), .rst_n(rst_n), .hsync(p_hs), .vsync(p_vs), .data_en(p_de),
    .x(p_x), .y(p_y), .line_start(p_ls), .frame_start(p_fs)
  );

  vt_t d_o, s_o, p_o;
  assign d_o = {d_hs, d_vs, d_de, d_x, d_y, d_ls, d_fs};
  assign s_o = {s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs};
  assign p_o = {p_hs, p_vs, p_de, p_x, p_y, p_ls, p_fs};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;  // rising edges seen since the last reset release

  int def_de, def_hs, def_hs_rise, def_ls1, def_ls2;
  int sm_de, sm_vs, sm_vs_rise, sm_vs_rise_ls, sm_fs1, sm_fs2, sm_last_px;
  int pol_hs_low, pol_vs_low;
  vt_t sm_at_wrap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Position p is the raster index (pixels since frame origin); p < 0 means in reset.
  function automatic vt_t model(input int p, input int ha, input int hf, input int hsw,
                                input int hb, input int va, input int vf, input int vsw,
                                input int vb, input bit hpol, input bit vpol);
    vt_t r;
    int ht, vt, h, v;
    r = '0;
    if (p < 0) begin
      r.hs = ~hpol;
      r.vs = ~vpol;
      return r;
    end
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    h  = p % ht;
    v  = (p / ht) % vt;
    r.de = (h < ha) && (v < va);
    r.hs = (h >= ha + hf && h < ha + hf + hsw) ? hpol : ~hpol;
    r.vs = (v >= va + vf && v < va + vf + vsw) ? vpol : ~vpol;
    r.x  = r.de ? 11'(h) : 11'd0;
    r.y  = r.de ? 10'(v) : 10'd0;
    r.ls = (h == 0);
    r.fs = (h == 0) && (v == 0);
    return r;
  endfunction

  task automatic clear_stats();
    def_de = 0; def_hs = 0; def_hs_rise = 0; def_ls1 = 0; def_ls2 = 0;
    sm_de = 0; sm_vs = 0; sm_vs_rise = 0; sm_vs_rise_ls = 0;
    sm_fs1 = 0; sm_fs2 = 0; sm_last_px = 0; sm_at_wrap = '0;
    pol_hs_low = 0; pol_vs_low = 0;
  endtask

  // One clock: sample #1 after the edge, compare every instance to the model, gather stats.
  task automatic step();
    int p;
    @(posedge clk);
    #1;
    if (rst_n) cyc++;
    else cyc = 0;
    p = (rst_n && cyc > 0) ? cyc - 1 : -1;
    check("def_raster",   64'(d_o), 64'(model(p, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1)));
    check("small_raster", 64'(s_o), 64'(model(p, 8, 2, 3, 1, 4, 1, 2, 1, 1'b1, 1'b1)));
    check("pol_raster",   64'(p_o), 64'(model(p, 8, 2, 3, 1, 4, 1, 2, 1, 1'b0, 1'b0)));
    if (cyc >= 1 && cyc <= 1056) begin
      if (d_de) def_de++;
      if (d_hs) def_hs++;
      if (d_hs && def_hs_rise == 0) def_hs_rise = cyc;
    end
    if (cyc >= 1 && d_ls) begin
      if (def_ls1 == 0) def_ls1 = cyc;
      else if (def_ls2 == 0) def_ls2 = cyc;
    end
    if (cyc >= 1 && cyc <= 112) begin
      if (s_de) sm_de++;
      if (s_vs) sm_vs++;
      if (s_vs && sm_vs_rise == 0) begin
        sm_vs_rise    = cyc;
        sm_vs_rise_ls = int'(s_ls);
      end
      if (s_de && s_x == 11'd7 && s_y == 10'd3) sm_last_px = cyc;
      if (!p_hs) pol_hs_low++;
      if (!p_vs) pol_vs_low++;
    end
    if (cyc >= 1 && s_fs) begin
      if (sm_fs1 == 0) sm_fs1 = cyc;
      else if (sm_fs2 == 0) begin
        sm_fs2     = cyc;
        sm_at_wrap = s_o;
      end
    end
  endtask

  initial begin
    int n;
    clear_stats();
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_def_de",  64'(d_de), 64'(0));
    check("rst_def_hs",  64'(d_hs), 64'(0));
    check("rst_def_vs",  64'(d_vs), 64'(0));
    check("rst_pol_hs",  64'(p_hs), 64'(1));
    check("rst_pol_vs",  64'(p_vs), 64'(1));

    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("first_de", 64'(d_de), 64'(1));
    check("first_fs", 64'(d_fs), 64'(1));
    check("first_ls", 64'(d_ls), 64'(1));
    check("first_x",  64'(d_x),  64'(0));
    check("first_y",  64'(d_y),  64'(0));
    check("first_hs", 64'(d_hs), 64'(0));
    check("first_vs", 64'(d_vs), 64'(0));

    repeat (1057) step();
    check("line_de_clocks", 64'(def_de), 64'(800));
    check("line_hs_clocks", 64'(def_hs), 64'(128));
    check("hs_after_ls",    64'(def_hs_rise - def_ls1), 64'(840));
    check("ls_period",      64'(def_ls2 - def_ls1), 64'(1056));
    check("sm_fs_period",   64'(sm_fs2 - sm_fs1), 64'(112));
    check("sm_de_frame",    64'(sm_de), 64'(32));
    check("sm_vs_frame",    64'(sm_vs), 64'(28));
    check("sm_vs_rise",     64'(sm_vs_rise), 64'(71));
    check("sm_vs_rise_ls",  64'(sm_vs_rise_ls), 64'(1));
    check("sm_wrap_gap",    64'(sm_fs2 - sm_last_px), 64'(63));
    check("sm_wrap_de",     64'(sm_at_wrap.de), 64'(1));
    check("sm_wrap_xy",     64'({sm_at_wrap.x, sm_at_wrap.y}), 64'(0));
    check("pol_hs_low",     64'(pol_hs_low), 64'(24));
    check("pol_vs_low",     64'(pol_vs_low), 64'(28));

    n = int'($urandom_range(100, 700));
    repeat (n) step();
    #5;
    rst_n = 1'b0;
    #1;
    check("async_def_de", 64'(d_de), 64'(0));
    check("async_def_hs", 64'(d_hs), 64'(0));
    check("async_def_vs", 64'(d_vs), 64'(0));
    check("async_def_xy", 64'({d_x, d_y}), 64'(0));
    check("async_def_ls", 64'({d_ls, d_fs}), 64'(0));
    check("async_pol_hs", 64'(p_hs), 64'(1));
    check("async_pol_vs", 64'(p_vs), 64'(1));

    n = int'($urandom_range(1, 4));
    repeat (n) step();
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    step();
    check("restart_def", 64'({d_de, d_fs, d_ls, d_x, d_y}), 64'({3'b111, 21'd0}));
    check("restart_sm",  64'({s_de, s_fs, s_ls, s_x, s_y}), 64'({3'b111, 21'd0}));

    n = int'($urandom_range(300, 900));
    repeat (n) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
